// File: rtl/module_countdown_timer.sv
// Programmable down-counter with a clock prescaler.
// A load captures a start value and counts down to zero, one step every
// PRESCALE cycles, then pulses done_o for one cycle.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: on reaching zero the last nonzero
// load value is reloaded and counting continues, giving a periodic done_o.
module module_countdown_timer #(
  parameter int PRESCALE = 10,
  parameter int WIDTH    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o
);

  // Prescaler needs at least one bit, even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [PW-1:0]    pre_reg;
  logic             done_reg;
  logic             tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_reg;
`endif

  assign tick    = (pre_reg == PW'(PRESCALE - 1));
  assign count_o = count_reg;
  assign busy_o  = (state_reg == S_RUN);
  assign done_o  = done_reg;

  // Control FSM, prescaler and count register; abort beats load beats tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      pre_reg   <= '0;
      done_reg  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (abort_i) begin
        // Abort freezes the count where it is; in IDLE this changes nothing.
        state_reg <= S_IDLE;
        pre_reg   <= '0;
      end else if (load_i) begin
        pre_reg <= '0;
        if (value_i != '0) begin
          count_reg <= value_i;
          state_reg <= S_RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          reload_reg <= value_i;
`endif
        end else begin
          // Zero load completes immediately.
          count_reg <= '0;
          done_reg  <= 1'b1;
          state_reg <= S_IDLE;
        end
      end else if (state_reg == S_RUN) begin
        if (tick) begin
          pre_reg <= '0;
          if (count_reg == WIDTH'(1)) begin
            done_reg <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count_reg <= reload_reg;
`else
            count_reg <= '0;
            state_reg <= S_IDLE;
`endif
          end else begin
            count_reg <= count_reg - WIDTH'(1);
          end
        end else begin
          pre_reg <= pre_reg + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_module_countdown_timer.sv
// Self-checking bench for module_countdown_timer.
// The reference model tracks elapsed cycles since the last load and derives
// the expected count arithmetically as N - elapsed/PRESCALE.
module tb_module_countdown_timer;
  localparam int P = 10;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_i;
  logic [W-1:0] value_i;
  logic         abort_i;
  logic [W-1:0] count_o;
  logic         busy_o;
  logic         done_o;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model state
  int  m_run  = 0;
  int  m_n    = 0;
  int  m_t    = 0;
  int  m_cnt  = 0;
  int  m_done = 0;

  module_countdown_timer #(.PRESCALE(P), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_i),
    .value_i (value_i),
    .abort_i (abort_i),
    .count_o (count_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  // Apply the model's view of one clock edge given the sampled inputs.
  task automatic model_edge(input logic r, input logic ld, input int v, input logic ab);
    m_done = 0;
    if (!r) begin
      m_run = 0; m_cnt = 0; m_t = 0;
    end else if (ab) begin
      m_run = 0;
    end else if (ld) begin
      if (v == 0) begin
        m_run = 0; m_cnt = 0; m_done = 1;
      end else begin
        m_run = 1; m_n = v; m_t = 0; m_cnt = v;
      end
    end else if (m_run != 0) begin
      m_t   = m_t + 1;
      m_cnt = m_n - m_t / P;
      if (m_t == m_n * P) begin
        m_done = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_t   = 0;
        m_cnt = m_n;
`else
        m_run = 0;
        m_cnt = 0;
`endif
      end
    end
  endtask

  task automatic check(input string tag);
    n_asserts++;
    assert (count_o === W'(m_cnt)) else begin
      n_fail++;
      $error("FAIL %s count: got %0d want %0d", tag, count_o, m_cnt);
    end
    n_asserts++;
    assert (busy_o === (m_run != 0)) else begin
      n_fail++;
      $error("FAIL %s busy: got %0b want %0d", tag, busy_o, m_run);
    end
    n_asserts++;
    assert (done_o === (m_done != 0)) else begin
      n_fail++;
      $error("FAIL %s done: got %0b want %0d", tag, done_o, m_done);
    end
  endtask

  // One clock cycle: drive inputs, clock, update model, check outputs.
  task automatic step(input string tag, input logic r, input logic ld, input int v, input logic ab);
    rst = r; load_i = ld; value_i = W'(v); abort_i = ab;
    @(posedge clk);
    model_edge(r, ld, v, ab);
    #1;
    check(tag);
  endtask

  task automatic idle_steps(input string tag, input int k);
    for (int i = 0; i < k; i++) step(tag, 1'b1, 1'b0, 0, 1'b0);
  endtask

  // Run until the model count reaches a target (bounded).
  task automatic run_to_count(input string tag, input int target);
    for (int i = 0; i < 1000 && m_cnt != target; i++) step(tag, 1'b1, 1'b0, 0, 1'b0);
    n_asserts++;
    assert (count_o === W'(target)) else begin
      n_fail++;
      $error("FAIL %s reach: got %0d want %0d", tag, count_o, target);
    end
  endtask

  int cyc;
  int done_seen;

  initial begin
    rst = 1'b0; load_i = 1'b0; value_i = '0; abort_i = 1'b0;

    // 1: reset held with a pending load; first released edge samples the load
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b1, 7, 1'b0);
    step("reset_release_load", 1'b1, 1'b1, 7, 1'b0);
    idle_steps("run7", 7 * P);

    // 2: load 3, done exactly 30 cycles later
    step("load3", 1'b1, 1'b1, 3, 1'b0);
    idle_steps("run3", 3 * P + 5);

    // 3: load 63, explicit latency measurement
    step("load63", 1'b1, 1'b1, 63, 1'b0);
    cyc = 0; done_seen = 0;
    for (int i = 0; i < 700 && done_seen == 0; i++) begin
      step("run63", 1'b1, 1'b0, 0, 1'b0);
      cyc++;
      if (done_o) done_seen = 1;
    end
    n_asserts++;
    assert (cyc == 63 * P) else begin
      n_fail++;
      $error("FAIL latency63: got %0d want %0d", cyc, 63 * P);
    end
    idle_steps("after63", 20);

    // 4: abort at 5, then load 2
    step("load8", 1'b1, 1'b1, 8, 1'b0);
    run_to_count("run8", 5);
    step("abort", 1'b1, 1'b0, 0, 1'b1);
    idle_steps("held5", 15);
    step("load2", 1'b1, 1'b1, 2, 1'b0);
    idle_steps("run2", 2 * P + 3);

    // 5: zero load, then load with abort in IDLE
    step("load0", 1'b1, 1'b1, 0, 1'b0);
    idle_steps("after0", 3);
    step("load4_abort", 1'b1, 1'b1, 4, 1'b1);
    idle_steps("no_start", 12);

    // Restart during RUN, abort+load in RUN, zero load in RUN
    step("load5", 1'b1, 1'b1, 5, 1'b0);
    idle_steps("run5", 13);
    step("reload9", 1'b1, 1'b1, 9, 1'b0);
    idle_steps("run9", 7);
    step("abort_load_run", 1'b1, 1'b1, 3, 1'b1);
    idle_steps("held", 4);
    step("load3b", 1'b1, 1'b1, 3, 1'b0);
    idle_steps("run3b", 4);
    step("load0_run", 1'b1, 1'b1, 0, 1'b0);
    idle_steps("after0_run", 3);

    // 6: reset mid-run, then periodic behaviour (build-dependent)
    step("load6", 1'b1, 1'b1, 6, 1'b0);
    run_to_count("run6", 4);
    step("rst_mid", 1'b0, 1'b0, 0, 1'b0);
    idle_steps("post_rst", 3);
    step("load2p", 1'b1, 1'b1, 2, 1'b0);
    idle_steps("periodic", 3 * 2 * P + 2);
    step("abort_p", 1'b1, 1'b0, 0, 1'b1);
    idle_steps("stopped", 5);

    // Randomized phase
    for (int i = 0; i < 2500; i++) begin
      automatic logic r  = ($urandom_range(0, 299) != 0);
      automatic logic ld = ($urandom_range(0, 39) == 0);
      automatic logic ab = ($urandom_range(0, 79) == 0);
      automatic int   v  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                                       : int'($urandom_range(0, 6));
      step("random", r, ld, v, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
